kmouse_update_scheduler: RTL and testbench
==========================================

Name: kmouse_update_scheduler

Overview:
- Sequences writes into the Kempston mouse register bank (X, Y and button/wheel latches).
- The bank loads DO on rising edges of MX / MY / MKEY.
- Accepts decoded mouse packets over a valid/ready handshake and accumulates them into 8-bit X/Y coordinates and a 4-bit wheel counter.
- Issues one setup/strobe/hold write per changed register, and defers any new write while a Z80 read of the bank is in progress.

Parameters:
- SETUP_CYCLES, 2, CLK cycles DO is stable before strobe rise (1..15)
- STROBE_CYCLES, 2, CLK cycles strobe held high (1..15)
- HOLD_CYCLES, 2, CLK cycles DO held after strobe fall (1..15)
- SYNC_STAGES, 2, flops in the BUS_BUSY synchronizer (2..3)

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous reset, active low
- PKT_VALID  in  1  packet valid
- PKT_READY  out  1  packet accepted when VALID & READY at CLK rise
- PKT_DX  in  9  signed X delta, positive = right
- PKT_DY  in  9  signed Y delta, positive = up
- PKT_BTN  in  3  {middle,right,left}, 1 = pressed
- PKT_DZ  in  4  signed wheel delta
- BUS_BUSY  in  1  asynchronous; high while the Z80 read of any bank port is active (~RD & ~IORQ & decode)
- DO  out  8  data to bank DI
- MX  out  1  X latch strobe
- MY  out  1  Y latch strobe
- MKEY  out  1  button/wheel latch strobe

Behaviour:
- Reset (async, RST_N low):
  - state = IDLE; x = 0, y = 0, wz = 0, btn = 0.
  - DO = 0; MX = MY = MKEY = 0.
  - All three dirty flags = 1, so the initial values are written after reset release.
  - Reset mid-strobe drops the strobe low immediately. No partial-write recovery is required; the dirty flags force a full rewrite.
- PKT_READY = (state == IDLE) && no dirty flag set. It is a registered-state decode, with no combinational path from PKT_VALID.
- On accept:
  - x += PKT_DX[7:0] and y += PKT_DY[7:0], modulo 256 (wrap-around; no clamping).
  - wz += PKT_DZ, modulo 16.
  - btn = PKT_BTN.
  - Dirty flags: dX if PKT_DX[7:0] != 0; dY if PKT_DY[7:0] != 0; dK if PKT_BTN != btn or PKT_DZ != 0.
  - A packet with zero deltas and unchanged buttons sets no flag.
- Key byte: {wz, 1'b1, ~btn[2], ~btn[1], ~btn[0]} (D3 = 1, buttons active low).
- BUS_BUSY passes through SYNC_STAGES flops to give busy_s.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
  - IDLE: if any dirty flag set and busy_s = 0, select the target by priority KEY > X > Y. Load DO from the current value, clear that dirty flag and go to SETUP. If busy_s = 1, wait; no strobe starts.
  - SETUP: count SETUP_CYCLES, then raise the selected strobe and go to STROBE.
  - STROBE: count STROBE_CYCLES, then drop the strobe and go to HOLD.
  - HOLD: count HOLD_CYCLES holding DO, then go to IDLE.
- busy_s rising after SETUP has been entered does not abort the write; the sequence completes.
- Exactly one strobe is high at any time; DO changes only in IDLE.
- Minimum write latency from accept: 1 (IDLE decision) + SETUP_CYCLES cycles to strobe rise.
- A full 3-register update takes 3 × (1 + SETUP + STROBE + HOLD) cycles with busy_s low.
- Since PKT_READY is low while anything is dirty, no accumulation races with a pending write.

Optional Feature:
- Macro: KMOUSE_WHEEL_EN.
- Defined: wheel accumulated as above; D4-D7 of the key byte = wz; PKT_DZ != 0 sets dK.
- Undefined: PKT_DZ ignored; the wz register is removed; D4-D7 = 4'b1111 (wheel off); only button changes set dK.

Decomposition:
- Shared package kmouse_pkg:
  - State enum (IDLE, SETUP, STROBE, HOLD) and target enum (TGT_KEY, TGT_X, TGT_Y).
  - Port-address constants 16'hFADF, 16'hFBDF, 16'hFFDF.
  - Key-byte bit positions (BTN_L = 0, BTN_R = 1, BTN_M = 2, RSVD = 3, WHEEL_LSB = 4).
  - Reset constant KEY_IDLE = 8'hFF.
- One natural sub-module: kmouse_sync, a SYNC_STAGES-deep async-reset synchronizer for BUS_BUSY.

Test Plan:
- Release reset, BUS_BUSY = 0, defaults:
  - MKEY strobe with DO = 8'h0F (wheel enabled) or 8'hFF (disabled).
  - Then MX with DO = 00, then MY with DO = 00.
  - Each strobe is high 2 cycles, with DO stable 2 cycles before and after.
- Packet DX = +5, DY = -3, BTN = 0, DZ = 0:
  - Only MX (DO = 05) then MY (DO = FD) are written; no MKEY.
  - PKT_READY stays low until the MY HOLD ends.
- x = 8'hFE, then packet DX = +4 -> MX write DO = 02 (wrap). Packet DX = 9'h100 (-256) -> no dirty flag, no strobe.
- BTN = 3'b001, DZ = +1 (wheel enabled, wz = 0): MKEY write DO = 8'h1E. With the macro undefined: DO = 8'hFE.
- Hold BUS_BUSY high 20 cycles with dX pending: MX stays low throughout. MX rises SYNC_STAGES + 1 + SETUP_CYCLES cycles after BUS_BUSY falls.
- Assert RST_N low during STROBE of MX: MX falls asynchronously. After release, all three registers are rewritten with x = y = 0.

Source files
------------

// File: rtl/kmouse_pkg.sv
// Shared types and constants for the Kempston mouse register-bank update scheduler.
package kmouse_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;
  typedef enum logic [1:0] {TGT_KEY = 2'd0, TGT_X = 2'd1, TGT_Y = 2'd2} tgt_e;

  localparam logic [15:0] PORT_KEY = 16'hFADF;
  localparam logic [15:0] PORT_X   = 16'hFBDF;
  localparam logic [15:0] PORT_Y   = 16'hFFDF;

  localparam int BTN_L     = 0;
  localparam int BTN_R     = 1;
  localparam int BTN_M     = 2;
  localparam int RSVD      = 3;
  localparam int WHEEL_LSB = 4;

  localparam logic [7:0] KEY_IDLE = 8'hFF;

  // Buttons are active low on the bus; the reserved bit stays high.
  function automatic logic [7:0] key_byte(input logic [3:0] wz, input logic [2:0] btn);
    logic [7:0] k;
    k                  = KEY_IDLE;
    k[WHEEL_LSB +: 4]  = wz;
    k[BTN_L]           = ~btn[0];
    k[BTN_R]           = ~btn[1];
    k[BTN_M]           = ~btn[2];
    return k;
  endfunction

endpackage

// File: rtl/kmouse_sync.sv
// Async-reset multi-flop synchronizer for the Z80 bus-busy indication.
module kmouse_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ff_q <= '0;
    else          ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/kmouse_update_scheduler.sv
// Accumulates mouse packets and writes changed X/Y/key registers with setup/strobe/hold timing.
// Wheel support is compiled in when KMOUSE_WHEEL_EN is defined.
module kmouse_update_scheduler
  import kmouse_pkg::*;
#(
  parameter int SETUP_CYCLES  = 2,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 2,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pkt_valid_i,
  output logic       pkt_ready_o,
  input  logic [8:0] pkt_dx_i,
  input  logic [8:0] pkt_dy_i,
  input  logic [2:0] pkt_btn_i,
  input  logic [3:0] pkt_dz_i,
  input  logic       bus_busy_i,
  output logic [7:0] do_o,
  output logic       mx_o,
  output logic       my_o,
  output logic       mkey_o
);

  localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);

  state_e     state_q, state_d;
  tgt_e       tgt_q, tgt_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] x_q, x_d, y_q, y_d, do_q, do_d;
  logic [2:0] btn_q, btn_d, dirty_q, dirty_d, stb_q, stb_d;
  logic [3:0] wz_cur;
  logic       busy_s, accept, dk;
  logic       unused_sign;

  kmouse_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (bus_busy_i),
    .q_o    (busy_s)
  );

  // Only the low byte of each delta matters: accumulation is modulo 256.
  assign unused_sign = pkt_dx_i[8] ^ pkt_dy_i[8];

  assign pkt_ready_o = (state_q == IDLE) && (dirty_q == 3'b000);
  assign accept      = pkt_valid_i && pkt_ready_o;

`ifdef KMOUSE_WHEEL_EN
  logic [3:0] wz_q, wz_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) wz_q <= '0;
    else          wz_q <= wz_d;
  end

  always_comb begin
    wz_d = wz_q;
    if (accept) wz_d = wz_q + pkt_dz_i;
  end

  assign wz_cur = wz_q;
  assign dk     = (pkt_btn_i != btn_q) || (pkt_dz_i != 4'd0);
`else
  logic unused_dz;
  assign unused_dz = ^pkt_dz_i;
  assign wz_cur    = 4'hF;
  assign dk        = (pkt_btn_i != btn_q);
`endif

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    btn_d   = btn_q;
    dirty_d = dirty_q;
    do_d    = do_q;
    stb_d   = stb_q;

    // accept only happens in IDLE with nothing dirty, so it never overlaps a write
    if (accept) begin
      x_d            = x_q + pkt_dx_i[7:0];
      y_d            = y_q + pkt_dy_i[7:0];
      btn_d          = pkt_btn_i;
      dirty_d[TGT_X]   = (pkt_dx_i[7:0] != 8'd0);
      dirty_d[TGT_Y]   = (pkt_dy_i[7:0] != 8'd0);
      dirty_d[TGT_KEY] = dk;
    end

    case (state_q)
      IDLE: begin
        if ((dirty_q != 3'b000) && !busy_s) begin
          if (dirty_q[TGT_KEY]) begin
            tgt_d            = TGT_KEY;
            do_d             = key_byte(wz_cur, btn_q);
            dirty_d[TGT_KEY] = 1'b0;
          end else if (dirty_q[TGT_X]) begin
            tgt_d          = TGT_X;
            do_d           = x_q;
            dirty_d[TGT_X] = 1'b0;
          end else begin
            tgt_d          = TGT_Y;
            do_d           = y_q;
            dirty_d[TGT_Y] = 1'b0;
          end
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = '0;
          stb_d   = 3'b001 << tgt_q;
          state_d = STROBE;
        end else cnt_d = cnt_q + 4'd1;
      end
      STROBE: begin
        if (cnt_q == STROBE_LAST) begin
          cnt_d   = '0;
          stb_d   = '0;
          state_d = HOLD;
        end else cnt_d = cnt_q + 4'd1;
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else cnt_d = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // All dirty after reset so the bank is rewritten with the reset values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      tgt_q   <= TGT_KEY;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      btn_q   <= '0;
      dirty_q <= 3'b111;
      do_q    <= '0;
      stb_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      btn_q   <= btn_d;
      dirty_q <= dirty_d;
      do_q    <= do_d;
      stb_q   <= stb_d;
    end
  end

  assign do_o   = do_q;
  assign mkey_o = stb_q[TGT_KEY];
  assign mx_o   = stb_q[TGT_X];
  assign my_o   = stb_q[TGT_Y];

endmodule

// File: tb/tb_kmouse_update_scheduler.sv
// Self-checking bench: vector table, timing corner sequences and randomized packets vs a write-list model.
module tb_kmouse_update_scheduler;

  localparam int S  = 2;
  localparam int ST = 2;
  localparam int H  = 2;
  localparam int SY = 2;
  localparam int WR_CYC = 1 + S + ST + H;

`ifdef KMOUSE_WHEEL_EN
  localparam logic [7:0] KB5 = 8'h1E;
  localparam logic [7:0] KB7 = 8'h09;
  localparam logic [7:0] KB9 = 8'h39;
  localparam logic [2:0] M9  = 3'b001;
`else
  localparam logic [7:0] KB5 = 8'hFE;
  localparam logic [7:0] KB7 = 8'hF9;
  localparam logic [7:0] KB9 = 8'h00;
  localparam logic [2:0] M9  = 3'b000;
`endif

  logic       clk = 1'b0, rst_n = 1'b0, valid = 1'b0, bus_busy = 1'b0;
  logic       ready, mx, my, mkey;
  logic [8:0] dx = '0, dy = '0;
  logic [2:0] btn = '0;
  logic [3:0] dz = '0;
  logic [7:0] dout;

  always #5 clk = ~clk;

  kmouse_update_scheduler #(
    .SETUP_CYCLES(S), .STROBE_CYCLES(ST), .HOLD_CYCLES(H), .SYNC_STAGES(SY)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .pkt_valid_i(valid), .pkt_ready_o(ready),
    .pkt_dx_i(dx), .pkt_dy_i(dy), .pkt_btn_i(btn), .pkt_dz_i(dz),
    .bus_busy_i(bus_busy), .do_o(dout), .mx_o(mx), .my_o(my), .mkey_o(mkey)
  );

  typedef struct packed {logic [1:0] tgt; logic [7:0] data;} wr_t;
  typedef struct {
    logic [8:0] dx, dy; logic [2:0] btn; logic [3:0] dz;
    logic [2:0] mask; logic [7:0] kb, xb, yb;
  } vec_t;

  wr_t  obs_q[$], exp_q[$];
  vec_t tbl[9];
  int   tests = 0, fails = 0;
  bit   rand_busy = 0;

  logic [7:0] m_x = '0, m_y = '0;
  logic [2:0] m_btn = '0;
  logic [3:0] m_wz = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_ge(input string nm, input int act, input int lo);
    tests++;
    if (act < lo) begin
      fails++;
      $display("FAIL %s: got %0d want >= %0d", nm, act, lo);
    end
  endtask

  function automatic logic [7:0] key_of(input logic [3:0] wz, input logic [2:0] b);
`ifdef KMOUSE_WHEEL_EN
    return {wz, 1'b1, ~b[2], ~b[1], ~b[0]};
`else
    return {4'hF, 1'b1, ~b[2], ~b[1], ~b[0]};
`endif
  endfunction

  // Strobe monitor: records every write and checks setup/width/hold around it.
  logic [2:0] stb_prev = '0, stb_now, rise;
  logic [7:0] do_prev = '0;
  int do_run = 0, width = 0, since_fall = 99;
  initial forever begin
    @(negedge clk);
    stb_now = {my, mx, mkey};
    if (rst_n !== 1'b1) begin
      stb_prev = '0; since_fall = 99; do_run = 0; width = 0; do_prev = dout;
    end else begin
      if (since_fall < 99) since_fall++;
      if (dout !== do_prev) begin
        chk_ge("do_hold_after_strobe", since_fall, H + 1);
        do_run = 0;
      end else do_run++;
      do_prev = dout;
      rise = stb_now & ~stb_prev;
      if (rise != 3'b000) begin
        chk("strobe_onehot", $countones(stb_now), 1);
        chk_ge("do_setup", do_run, S);
        chk("ready_low_in_write", ready, 0);
        obs_q.push_back({rise[0] ? 2'd0 : (rise[1] ? 2'd1 : 2'd2), dout});
        width = 1;
      end else if (stb_now != 3'b000) width++;
      if (stb_prev != 3'b000 && stb_now == 3'b000) begin
        chk("strobe_width", width, ST);
        since_fall = 0;
      end
      stb_prev = stb_now;
    end
  end

  task automatic accept_pkt(input logic [8:0] pdx, input logic [8:0] pdy,
                            input logic [2:0] pb, input logic [3:0] pdz, input bit push);
    int  n;
    bit  dk;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk("ready_before_pkt", ready, 1);
    dx = pdx; dy = pdy; btn = pb; dz = pdz; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    dk = (pb != m_btn);
`ifdef KMOUSE_WHEEL_EN
    dk   = dk || (pdz != 4'd0);
    m_wz = m_wz + pdz;
`endif
    m_btn = pb;
    m_x   = m_x + pdx[7:0];
    m_y   = m_y + pdy[7:0];
    if (push) begin
      if (dk)               exp_q.push_back({2'd0, key_of(m_wz, m_btn)});
      if (pdx[7:0] != 8'd0) exp_q.push_back({2'd1, m_x});
      if (pdy[7:0] != 8'd0) exp_q.push_back({2'd2, m_y});
    end
  endtask

  task automatic drain_and_compare(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 500) begin
      if (rand_busy) bus_busy = ($urandom_range(0, 2) == 0);
      @(negedge clk); n++;
    end
    bus_busy = 1'b0;
    chk({nm, "_done"}, ready, 1);
    chk({nm, "_nwrites"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_w%0d_tgt", nm, i), obs_q[i].tgt, exp_q[i].tgt);
      chk($sformatf("%s_w%0d_data", nm, i), obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [8:0] rdx, rdy;
    logic [2:0] rb;
    logic [3:0] rz;

    tbl[0] = '{9'h005, 9'h1FD, 3'b000, 4'h0, 3'b110, 8'h00, 8'h05, 8'hFD};
    tbl[1] = '{9'h100, 9'h000, 3'b000, 4'h0, 3'b000, 8'h00, 8'h00, 8'h00};
    tbl[2] = '{9'h0F9, 9'h000, 3'b000, 4'h0, 3'b010, 8'h00, 8'hFE, 8'h00};
    tbl[3] = '{9'h004, 9'h000, 3'b000, 4'h0, 3'b010, 8'h00, 8'h02, 8'h00};
    tbl[4] = '{9'h000, 9'h000, 3'b001, 4'h1, 3'b001, KB5,   8'h00, 8'h00};
    tbl[5] = '{9'h000, 9'h000, 3'b001, 4'h0, 3'b000, 8'h00, 8'h00, 8'h00};
    tbl[6] = '{9'h000, 9'h000, 3'b110, 4'hF, 3'b001, KB7,   8'h00, 8'h00};
    tbl[7] = '{9'h1FF, 9'h001, 3'b110, 4'h0, 3'b110, 8'h00, 8'h01, 8'hFE};
    tbl[8] = '{9'h000, 9'h000, 3'b110, 4'h3, M9,     KB9,   8'h00, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_do", dout, 8'h00);
    chk("reset_strobes", {my, mx, mkey}, 3'b000);
    chk("reset_ready", ready, 0);

    exp_q.push_back({2'd0, key_of(4'd0, 3'd0)});
    exp_q.push_back({2'd1, 8'h00});
    exp_q.push_back({2'd2, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ready !== 1'b1 && n < 200);
    chk("full_update_cycles", n, 3 * WR_CYC);
    drain_and_compare("reset_defaults");

    foreach (tbl[i]) begin
      accept_pkt(tbl[i].dx, tbl[i].dy, tbl[i].btn, tbl[i].dz, 1'b0);
      if (tbl[i].mask[0]) exp_q.push_back({2'd0, tbl[i].kb});
      if (tbl[i].mask[1]) exp_q.push_back({2'd1, tbl[i].xb});
      if (tbl[i].mask[2]) exp_q.push_back({2'd2, tbl[i].yb});
      drain_and_compare($sformatf("vec%0d", i));
    end

    // accept -> strobe latency
    accept_pkt(9'd1, 9'd0, m_btn, 4'd0, 1'b1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (mx !== 1'b1 && n < 50);
    chk("accept_to_mx_cycles", n, 1 + S);
    drain_and_compare("latency");

    // bus busy defers the write
    bus_busy = 1'b1;
    repeat (4) @(posedge clk);
    accept_pkt(9'd3, 9'd0, m_btn, 4'd0, 1'b1);
    n = 0;
    repeat (20) begin @(posedge clk); #1; if (mx === 1'b1) n++; end
    chk("busy_mx_high_cycles", n, 0);
    chk("busy_no_write", obs_q.size(), 0);
    bus_busy = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (mx !== 1'b1 && n < 50);
    chk("busy_release_to_mx", n, SY + 1 + S);
    drain_and_compare("busy");

    // reset in the middle of an MX strobe
    accept_pkt(9'd7, 9'd0, m_btn, 4'd0, 1'b1);
    n = 0;
    while (mx !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    chk("rst_test_mx_seen", mx, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_mx_low", mx, 0);
    chk("rst_async_do", dout, 8'h00);
    repeat (3) @(posedge clk);
    obs_q.delete();
    exp_q.delete();
    m_x = '0; m_y = '0; m_btn = '0; m_wz = '0;
    exp_q.push_back({2'd0, key_of(4'd0, 3'd0)});
    exp_q.push_back({2'd1, 8'h00});
    exp_q.push_back({2'd2, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    drain_and_compare("post_reset");

    rand_busy = 1;
    for (int k = 0; k < 30; k++) begin
      rdx = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(0, 511));
      rdy = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom_range(0, 511));
      rb  = ($urandom_range(0, 1) == 0) ? m_btn : 3'($urandom_range(0, 7));
      rz  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      accept_pkt(rdx, rdy, rb, rz, 1'b1);
      drain_and_compare($sformatf("rand%0d", k));
    end
    rand_busy = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
